// File: rtl/psg_multi.sv
// psg_multi: NUM_CH square-wave tone channels sharing one LFSR noise source, with a
// two-port CPU register interface, per-channel sigma-delta bits and a registered level mix.

module psg_chan #(
    parameter int TONE_BITS = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic [TONE_BITS-1:0] period,
    input  logic [3:0]           vol,
    input  logic                 tdis,
    input  logic                 ndis,
    input  logic                 noise,
    output logic [3:0]           level,
    output logic                 aout
);
    localparam logic [TONE_BITS-1:0] ONE = TONE_BITS'(1);

    logic [TONE_BITS-1:0] cnt;
    logic [TONE_BITS-1:0] p_eff;
    logic                 tone;
    logic [4:0]           acc;

    assign p_eff = (period == '0) ? ONE : period;
    assign level = ((tone | tdis) & (noise | ndis)) ? vol : 4'd0;
    assign aout  = acc[4];

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            tone <= 1'b0;
            acc  <= '0;
        end else begin
            if (tick) begin
                // >= so a period shortened below the running count wraps on the next tick
                if (cnt >= p_eff - ONE) begin
                    cnt  <= '0;
                    tone <= ~tone;
                end else begin
                    cnt  <= cnt + ONE;
                end
            end
            acc <= {1'b0, acc[3:0]} + {1'b0, level};
        end
    end
endmodule

module psg_multi #(
    parameter int NUM_CH    = 3,
    parameter int TONE_BITS = 12,
    parameter int TONE_DIV  = 112
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             a0,
    input  logic                             wr_tick,
    input  logic [7:0]                       wdata,
    input  logic                             rd_tick,
    output logic [7:0]                       rdata,
    output logic [NUM_CH-1:0]                aout,
    output logic [4+$clog2(NUM_CH+1)-1:0]    mix
);
    localparam int MIX_W  = 4 + $clog2(NUM_CH + 1);
    localparam int PW     = $clog2(TONE_DIV);
    localparam int A_TDIS = 3 * NUM_CH;
    localparam int A_NDIS = A_TDIS + 1;
    localparam int A_NPER = A_TDIS + 2;

    logic [7:0]                         addr;
    int                                 ai;
    logic [NUM_CH-1:0][TONE_BITS-1:0]   period;
    logic [NUM_CH-1:0][3:0]             vol;
    logic [NUM_CH-1:0]                  tdis;
    logic [NUM_CH-1:0]                  ndis;
    logic [4:0]                         nper;
    logic [7:0]                         rd_val;

    logic [PW-1:0]                      pcnt;
    logic                               tick;
    logic [5:0]                         ncnt;
    logic [5:0]                         nlim;
    logic [4:0]                         np;
    logic [16:0]                        lfsr;

    logic [NUM_CH-1:0][3:0]             level;
    logic [MIX_W-1:0]                   mix_sum;

    assign ai = int'(addr);

    // CPU register file; data writes land on the same edge and act from the next clock
    always_ff @(posedge clk) begin
        if (reset) begin
            addr   <= '0;
            period <= '0;
            vol    <= '0;
            tdis   <= '0;
            ndis   <= '0;
            nper   <= '0;
        end else if (wr_tick) begin
            if (!a0) begin
                addr <= wdata;
            end else begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (ai == 3*c)     period[c][7:0]           <= wdata;
                    if (ai == 3*c + 1) period[c][TONE_BITS-1:8] <= wdata[TONE_BITS-9:0];
                    if (ai == 3*c + 2) vol[c]                   <= wdata[3:0];
                end
                if (ai == A_TDIS) tdis <= wdata[NUM_CH-1:0];
                if (ai == A_NDIS) ndis <= wdata[NUM_CH-1:0];
                if (ai == A_NPER) nper <= wdata[4:0];
            end
        end
    end

    always_comb begin
        rd_val = 8'h00;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ai == 3*c)     rd_val = period[c][7:0];
            if (ai == 3*c + 1) rd_val = 8'(period[c][TONE_BITS-1:8]);
            if (ai == 3*c + 2) rd_val = {4'h0, vol[c]};
        end
        if (ai == A_TDIS) rd_val = 8'(tdis);
        if (ai == A_NDIS) rd_val = 8'(ndis);
        if (ai == A_NPER) rd_val = {3'b000, nper};
    end

    // Read data sees pre-write register contents on a same-cycle write
    always_ff @(posedge clk) begin
        if (reset)        rdata <= '0;
        else if (rd_tick) rdata <= a0 ? rd_val : addr;
    end

    assign tick = (pcnt == PW'(TONE_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) pcnt <= '0;
        else       pcnt <= tick ? '0 : pcnt + PW'(1);
    end

    assign np   = (nper == 5'd0) ? 5'd1 : nper;
    assign nlim = {np, 1'b0} - 6'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            ncnt <= '0;
            lfsr <= 17'h1;
        end else if (tick) begin
            if (ncnt >= nlim) begin
                ncnt <= '0;
                lfsr <= {lfsr[0] ^ lfsr[3], lfsr[16:1]};
            end else begin
                ncnt <= ncnt + 6'd1;
            end
        end
    end

    psg_chan #(.TONE_BITS(TONE_BITS)) u_ch [NUM_CH-1:0] (
        .clk    (clk),
        .reset  (reset),
        .tick   (tick),
        .period (period),
        .vol    (vol),
        .tdis   (tdis),
        .ndis   (ndis),
        .noise  (lfsr[0]),
        .level  (level),
        .aout   (aout)
    );

    always_comb begin
        mix_sum = '0;
        for (int c = 0; c < NUM_CH; c++) mix_sum = mix_sum + MIX_W'(level[c]);
    end

    always_ff @(posedge clk) begin
        if (reset) mix <= '0;
        else       mix <= mix_sum;
    end
endmodule

// File: tb/tb_psg_multi.sv
// Scoreboarded bench for psg_multi: register reads are queued and checked by a monitor;
// tone, noise, sigma-delta and reset behaviour are checked against hand-derived values.
`timescale 1ns/1ps
module tb_psg_multi;
    localparam int NUM_CH    = 3;
    localparam int TONE_BITS = 12;
    localparam int TONE_DIV  = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              a0 = 1'b0;
    logic              wr_tick = 1'b0;
    logic              rd_tick = 1'b0;
    logic [7:0]        wdata = 8'h00;
    logic [7:0]        rdata;
    logic [NUM_CH-1:0] aout;
    logic [5:0]        mix;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         edge_n = -1;
    logic       rd_vld = 1'b0;
    logic [7:0] exp_q[$];

    psg_multi #(.NUM_CH(NUM_CH), .TONE_BITS(TONE_BITS), .TONE_DIV(TONE_DIV)) dut (
        .clk     (clk),
        .reset   (reset),
        .a0      (a0),
        .wr_tick (wr_tick),
        .wdata   (wdata),
        .rd_tick (rd_tick),
        .rdata   (rdata),
        .aout    (aout),
        .mix     (mix)
    );

    always #5 clk = ~clk;

    // edge_n = 0 at the first edge that samples reset low
    always @(posedge clk) edge_n <= reset ? -1 : edge_n + 1;
    always @(posedge clk) rd_vld <= rd_tick & ~reset;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired", name);
    endtask

    always @(negedge clk) begin
        if (rd_vld) begin
            if (exp_q.size() == 0) fail("rd_unexpected");
            else check("rdata", int'(rdata), int'(exp_q.pop_front()));
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; a0 = 1'b0; wr_tick = 1'b0; rd_tick = 1'b0;
        step(3);
        reset = 1'b0;
    endtask

    task automatic wr(input logic [7:0] addr, input logic [7:0] data);
        a0 = 1'b0; wr_tick = 1'b1; wdata = addr;
        step();
        a0 = 1'b1; wdata = data;
        step();
        a0 = 1'b0; wr_tick = 1'b0;
    endtask

    // data write sampled on edge w
    task automatic wr_at(input logic [7:0] addr, input logic [7:0] data, input int w);
        while (edge_n < w - 2) step();
        check("sched", edge_n, w - 2);
        wr(addr, data);
    endtask

    task automatic rd(input logic [7:0] addr, input logic [7:0] exp);
        a0 = 1'b0; wr_tick = 1'b1; wdata = addr;
        step();
        wr_tick = 1'b0; a0 = 1'b1; rd_tick = 1'b1;
        exp_q.push_back(exp);
        step();
        rd_tick = 1'b0; a0 = 1'b0;
    endtask

    task automatic rd_latch(input logic [7:0] exp);
        a0 = 1'b0; rd_tick = 1'b1;
        exp_q.push_back(exp);
        step();
        rd_tick = 1'b0;
    endtask

    task automatic wait_edge(input int e);
        while (edge_n < e) step();
    endtask

    // skip one mix transition, then time nint half periods
    task automatic meas(input string name, input int nint, input int exp_int);
        int pv;
        int cnt;
        pv = int'(mix); cnt = 0;
        while (int'(mix) == pv && cnt < 200) begin step(); cnt++; end
        if (cnt >= 200) begin fail({name, "_start"}); return; end
        for (int i = 0; i < nint; i++) begin
            pv = int'(mix); cnt = 0;
            while (int'(mix) == pv && cnt < 200) begin step(); cnt++; end
            check({name, "_half"}, cnt, exp_int);
            check({name, "_lvl"}, int'(mix), 15 - pv);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: bound expired");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1);
    end

    initial begin
        logic [16:0] m;
        int c0, c1, c2, cnt;

        // reset state and read-back
        do_reset();
        check("rst_aout", int'(aout), 0);
        check("rst_mix", int'(mix), 0);
        check("rst_rdata", int'(rdata), 0);
        for (int a = 0; a <= 3*NUM_CH + 3; a++) rd(8'(a), 8'h00);
        wr(8'd1, 8'hFF);
        rd(8'd1, 8'h0F);
        rd_latch(8'h01);
        wr(8'd9, 8'hFF);
        rd(8'd9, 8'h07);

        // tone period 3: 12-clock halves, only channel 0 audible
        do_reset();
        wr(8'd0, 8'd3); wr(8'd9, 8'hFE); wr(8'd10, 8'hFF); wr(8'd2, 8'd15);
        meas("tone3", 3, 12);
        check("tone3_aout12", int'(aout[2:1]), 0);

        // counter at 5 when period shrinks to 2: wrap on the next tick (edge 63)
        do_reset();
        wr(8'd2, 8'd15); wr(8'd9, 8'hFE); wr(8'd10, 8'hFF);
        wr_at(8'd0, 8'd10, 40);
        wr_at(8'd0, 8'd2, 60);
        wait_edge(63); check("shrink_e63", int'(mix), 0);
        wait_edge(64); check("shrink_e64", int'(mix), 15);
        wait_edge(71); check("shrink_e71", int'(mix), 15);
        wait_edge(72); check("shrink_e72", int'(mix), 0);
        wr(8'd0, 8'd0);
        meas("per0", 2, TONE_DIV);
        wr(8'd0, 8'd1);
        meas("per1", 2, TONE_DIV);

        // sigma-delta densities and mix latency
        do_reset();
        wr(8'd9, 8'hFF); wr(8'd10, 8'hFF);
        wr(8'd2, 8'd15); wr(8'd8, 8'd0); wr(8'd5, 8'd8);
        check("mix_at_wr", int'(mix), 15);
        step();
        check("mix_plus1", int'(mix), 23);
        c0 = 0; c1 = 0; c2 = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            c0 += int'(aout[0]); c1 += int'(aout[1]); c2 += int'(aout[2]);
        end
        check("sd_ones15", c0, 15);
        check("sd_ones8", c1, 8);
        check("sd_ones0", c2, 0);

        // write/read collision returns the old value
        do_reset();
        wr(8'd2, 8'h05);
        a0 = 1'b1; wr_tick = 1'b1; rd_tick = 1'b1; wdata = 8'h09;
        exp_q.push_back(8'h05);
        step();
        wr_tick = 1'b0; rd_tick = 1'b0; a0 = 1'b0;
        rd(8'd2, 8'h09);

        // reset while a tone runs
        do_reset();
        wr(8'd0, 8'd1); wr(8'd2, 8'd15); wr(8'd9, 8'hFE); wr(8'd10, 8'hFF);
        rd(8'd2, 8'h0F);
        step(40);
        cnt = 0;
        while (int'(mix) != 15 && cnt < 50) begin step(); cnt++; end
        if (cnt >= 50) fail("midrst_mix15");
        reset = 1'b1;
        step();
        check("midrst_mix", int'(mix), 0);
        check("midrst_aout", int'(aout), 0);
        check("midrst_rdata", int'(rdata), 0);
        step(2);
        reset = 1'b0;
        rd_latch(8'h00);
        rd(8'd2, 8'h00);

        // noise on channel 1 only; LFSR state after k shifts visible after edge 8k+4
        wr(8'd9, 8'h07); wr(8'd10, 8'h05); wr(8'd5, 8'd15);
        m = 17'h1;
        for (int k = 0; k <= 40; k++) begin
            if (k >= 3) begin
                wait_edge(8*k + 4);
                check($sformatf("noise_k%0d", k), int'(mix), m[0] ? 15 : 0);
            end
            m = {m[0] ^ m[3], m[16:1]};
        end

        step(3);
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
